// File: rtl/fp_pkg.sv
// Shared floating-point definitions: sequencing states, flag bit positions
// and the default single-precision field widths.
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   localparam int FLG_INVALID   = 3;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_INEXACT   = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_MUL,
      S_NORM,
      S_ROUND,
      S_DONE
   } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a significand with guard/round/sticky bits.
// Shared between the multiplier and the adder.
module fp_round_rne #(
   parameter int SIG_W = 24
) (
   input  logic [SIG_W-1:0] sig_i,
   input  logic             guard_i,
   input  logic             round_i,
   input  logic             sticky_i,
   output logic [SIG_W-1:0] sig_o,
   output logic             carry_o,
   output logic             inexact_o
);

   logic inc;

   // a tie (guard set, nothing below) rounds up only when the LSB is odd
   assign inc                = guard_i & (round_i | sticky_i | sig_i[0]);
   assign {carry_o, sig_o}   = {1'b0, sig_i} + {{SIG_W{1'b0}}, inc};
   assign inexact_o          = guard_i | round_i | sticky_i;

endmodule

// File: rtl/fp_mul_param.sv
// Multi-cycle IEEE-style multiplier with DAZ/FTZ and round-to-nearest-even.
// Fixed 5-cycle latency from the accepting edge to the ready pulse.
//
// state    | meaning
// S_IDLE   | waiting for start; operands captured on the accepting edge
// S_UNPACK | classify operands, form special results and exponent sum
// S_MUL    | significand product
// S_NORM   | normalise product, extract guard/round/sticky
// S_ROUND  | round, renormalise, overflow/underflow handling
// S_DONE   | publish Y/flags and pulse ready on the way back to idle
module fp_mul_param
   import fp_pkg::*;
#(
   parameter int  EXP_W = EXP_W_DEF,
   parameter int  MAN_W = MAN_W_DEF,
   localparam int W     = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Y,
   output logic         ready,
   output logic         busy,
   output logic [3:0]   flags
);

   localparam int EW = EXP_W + 2;
   localparam int PW = 2 * (MAN_W + 1);

   localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
   localparam logic [EXP_W-1:0]     EXP_ONES = '1;
   localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   state_e               state_q;
   logic [W-1:0]         a_q, b_q, y_q, res_y_q, spec_y_q;
   logic [3:0]           flags_q, res_flags_q, spec_flags_q;
   logic                 ready_q, busy_q, sign_q, spec_q;
   logic signed [EW-1:0] exp_q;
   logic [MAN_W:0]       man_a_q, man_b_q, sig_q;
   logic [PW-1:0]        prod_q;
   logic                 g_q, r_q, s_q;

   logic                 sa, sb;
   logic [EXP_W-1:0]     ea, eb;
   logic [MAN_W-1:0]     fa, fb;
   logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic                 sign_d, spec_d;
   logic [W-1:0]         spec_y_d;
   logic [3:0]           spec_flags_d;
   logic signed [EW-1:0] exp_sum_d;

   logic [PW-1:0]        prod_n;
   logic [MAN_W:0]       sig_d;
   logic                 g_d, r_d, s_d;
   logic signed [EW-1:0] exp_norm_d;

   logic [MAN_W:0]       rnd_sig;
   logic                 rnd_carry, rnd_inexact;
   logic signed [EW-1:0] exp_fin_d;
   logic [MAN_W-1:0]     frac_fin_d;
   logic [W-1:0]         res_y_d;
   logic [3:0]           res_flags_d;

   assign sa = a_q[W-1];
   assign sb = b_q[W-1];
   assign ea = a_q[W-2 -: EXP_W];
   assign eb = b_q[W-2 -: EXP_W];
   assign fa = a_q[MAN_W-1:0];
   assign fb = b_q[MAN_W-1:0];

   // subnormals are treated as zero, so a zero exponent alone means zero
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);
   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);
   assign a_snan = a_nan && !fa[MAN_W-1];
   assign b_snan = b_nan && !fb[MAN_W-1];

   assign exp_sum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;

   always_comb begin
      sign_d       = sa ^ sb;
      spec_d       = 1'b1;
      spec_y_d     = '0;
      spec_flags_d = '0;
      if (a_nan || b_nan) begin
         spec_y_d                  = QNAN;
         spec_flags_d[FLG_INVALID] = a_snan || b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         spec_y_d                  = QNAN;
         spec_flags_d[FLG_INVALID] = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_y_d = {sign_d, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         spec_y_d = {sign_d, {(W-1){1'b0}}};
      end else begin
         spec_d = 1'b0;
      end
   end

   // left-align the product so the leading one sits at the MSB
   always_comb begin
      prod_n     = prod_q[PW-1] ? prod_q : (prod_q << 1);
      sig_d      = prod_n[PW-1 -: MAN_W+1];
      g_d        = prod_n[MAN_W];
      r_d        = prod_n[MAN_W-1];
      s_d        = |prod_n[MAN_W-2:0];
      exp_norm_d = exp_q + {{(EW-1){1'b0}}, prod_q[PW-1]};
   end

   fp_round_rne #(
      .SIG_W(MAN_W + 1)
   ) u_round (
      .sig_i    (sig_q),
      .guard_i  (g_q),
      .round_i  (r_q),
      .sticky_i (s_q),
      .sig_o    (rnd_sig),
      .carry_o  (rnd_carry),
      .inexact_o(rnd_inexact)
   );

   always_comb begin
      exp_fin_d                = exp_q + {{(EW-1){1'b0}}, rnd_carry};
      frac_fin_d               = rnd_carry ? rnd_sig[MAN_W:1] : rnd_sig[MAN_W-1:0];
      res_y_d                  = {sign_q, exp_fin_d[EXP_W-1:0], frac_fin_d};
      res_flags_d              = '0;
      res_flags_d[FLG_INEXACT] = rnd_inexact;
      if (spec_q) begin
         res_y_d     = spec_y_q;
         res_flags_d = spec_flags_q;
      end else if (exp_fin_d >= EXP_MAX) begin
         res_y_d                    = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
         res_flags_d[FLG_OVERFLOW]  = 1'b1;
         res_flags_d[FLG_INEXACT]   = 1'b1;
      end else if (exp_fin_d < EXP_ONE) begin
         res_y_d                    = {sign_q, {(W-1){1'b0}}};
         res_flags_d[FLG_UNDERFLOW] = 1'b1;
         res_flags_d[FLG_INEXACT]   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         y_q          <= '0;
         flags_q      <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         sign_q       <= 1'b0;
         spec_q       <= 1'b0;
         spec_y_q     <= '0;
         spec_flags_q <= '0;
         exp_q        <= '0;
         man_a_q      <= '0;
         man_b_q      <= '0;
         prod_q       <= '0;
         sig_q        <= '0;
         g_q          <= 1'b0;
         r_q          <= 1'b0;
         s_q          <= 1'b0;
         res_y_q      <= '0;
         res_flags_q  <= '0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  busy_q  <= 1'b1;
                  state_q <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               sign_q       <= sign_d;
               exp_q        <= exp_sum_d;
               man_a_q      <= {1'b1, fa};
               man_b_q      <= {1'b1, fb};
               spec_q       <= spec_d;
               spec_y_q     <= spec_y_d;
               spec_flags_q <= spec_flags_d;
               state_q      <= S_MUL;
            end
            S_MUL: begin
               prod_q  <= PW'(man_a_q) * PW'(man_b_q);
               state_q <= S_NORM;
            end
            S_NORM: begin
               sig_q   <= sig_d;
               g_q     <= g_d;
               r_q     <= r_d;
               s_q     <= s_d;
               exp_q   <= exp_norm_d;
               state_q <= S_ROUND;
            end
            S_ROUND: begin
               res_y_q     <= res_y_d;
               res_flags_q <= res_flags_d;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               y_q     <= res_y_q;
               flags_q <= res_flags_q;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign Y     = y_q;
   assign flags = flags_q;
   assign ready = ready_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_fp_mul_param.sv
// Self-checking bench for fp_mul_param: single and half precision instances,
// scoreboard queue of expected results, latency/busy/reset behaviour.
module tb_fp_mul_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0, b = '0, y;
   logic        ready, busy;
   logic [3:0]  flags;

   logic        start_h = 1'b0;
   logic [15:0] a_h = '0, b_h = '0, y_h;
   logic        ready_h, busy_h;
   logic [3:0]  flags_h;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] y;
      logic [3:0]  f;
   } exp_t;

   exp_t sb_q[$];

   fp_mul_param dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .A    (a),
      .B    (b),
      .Y    (y),
      .ready(ready),
      .busy (busy),
      .flags(flags)
   );

   fp_mul_param #(
      .EXP_W(5),
      .MAN_W(10)
   ) dut_h (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start_h),
      .A    (a_h),
      .B    (b_h),
      .Y    (y_h),
      .ready(ready_h),
      .busy (busy_h),
      .flags(flags_h)
   );

   always #5 clk = ~clk;

   task automatic push_exp(input logic [31:0] ey, input logic [3:0] ef);
      exp_t e;
      e.y = ey;
      e.f = ef;
      sb_q.push_back(e);
   endtask

   task automatic drive_op(input logic [31:0] ai, input logic [31:0] bi,
                           input logic [31:0] ey, input logic [3:0] ef);
      @(negedge clk);
      a     = ai;
      b     = bi;
      start = 1'b1;
      push_exp(ey, ef);
      @(negedge clk);
      start = 1'b0;
   endtask

   // called just after the accepting edge; poke_at>0 raises start for one
   // edge at that cycle count to probe that it is ignored
   task automatic wait_ready(input int poke_at, output int lat, output int busy_n);
      bit poked;
      poked  = 1'b0;
      lat    = 0;
      busy_n = busy ? 1 : 0;
      while (lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (poked) begin
            start = 1'b0;
            poked = 1'b0;
         end
         if (ready) break;
         if (busy) busy_n++;
         if (lat == poke_at) begin
            a     = 32'h41200000;
            b     = 32'h41200000;
            start = 1'b1;
            poked = 1'b1;
         end
      end
   endtask

   task automatic count_ready(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (ready) c++;
      end
   endtask

   task automatic test_reset;
      int   lat, bn;
      exp_t e;
      #12;
      total++;
      if (y !== 32'h0) begin bad++; $display("FAIL rst_y: got %h want 00000000", y); end
      total++;
      if (flags !== 4'h0) begin bad++; $display("FAIL rst_flags: got %b want 0000", flags); end
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", ready); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      // start present on the very first edge after release
      @(negedge clk);
      rst_n = 1'b1;
      a     = 32'h3F800000;
      b     = 32'h3F800000;
      start = 1'b1;
      push_exp(32'h3F800000, 4'b0000);
      @(negedge clk);
      start = 1'b0;
      wait_ready(-1, lat, bn);
      e = sb_q.pop_front();
      total++;
      if (lat !== 5) begin bad++; $display("FAIL first_lat: got %0d want 5", lat); end
      total++;
      if (y !== e.y) begin bad++; $display("FAIL first_y: got %h want %h", y, e.y); end
      total++;
      if (flags !== e.f) begin bad++; $display("FAIL first_flags: got %b want %b", flags, e.f); end
   endtask

   task automatic test_basic;
      int   lat, bn;
      exp_t e;
      drive_op(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
      wait_ready(-1, lat, bn);
      e = sb_q.pop_front();
      total++;
      if (y !== e.y) begin bad++; $display("FAIL basic_y: got %h want %h", y, e.y); end
      total++;
      if (flags !== e.f) begin bad++; $display("FAIL basic_flags: got %b want %b", flags, e.f); end
      total++;
      if (lat !== 5) begin bad++; $display("FAIL basic_lat: got %0d want 5", lat); end
      total++;
      if (bn !== 5) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 5", bn); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_ready: got %b want 0", busy); end
   endtask

   task automatic test_arith;
      logic [31:0] ta[12] = '{32'h3F800001, 32'h3F800001, 32'h7F7FFFFF, 32'h00800000,
                              32'hFF800000, 32'hC0000000, 32'h7FC00000, 32'h7F800001,
                              32'hFF800000, 32'h00000001, 32'h3F800001, 32'h00000000};
      logic [31:0] tb[12] = '{32'h3FC00000, 32'h3F800001, 32'h40000000, 32'h3F000000,
                              32'h00000000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                              32'h40000000, 32'hC0000000, 32'h3F7FFFFE, 32'h7F800000};
      logic [31:0] ty[12] = '{32'h3FC00002, 32'h3F800002, 32'h7F800000, 32'h00000000,
                              32'h7FC00000, 32'hC0C00000, 32'h7FC00000, 32'h7FC00000,
                              32'hFF800000, 32'h80000000, 32'h3F800000, 32'h7FC00000};
      logic [3:0]  tf[12] = '{4'b0001, 4'b0001, 4'b0101, 4'b0011,
                              4'b1000, 4'b0000, 4'b0000, 4'b1000,
                              4'b0000, 4'b0000, 4'b0001, 4'b1000};
      int   lat, bn;
      exp_t e;
      for (int i = 0; i < 12; i++) begin
         drive_op(ta[i], tb[i], ty[i], tf[i]);
         wait_ready(-1, lat, bn);
         e = sb_q.pop_front();
         total++;
         if (y !== e.y) begin
            bad++;
            $display("FAIL arith%0d_y (%h x %h): got %h want %h", i, ta[i], tb[i], y, e.y);
         end
         total++;
         if (flags !== e.f) begin
            bad++;
            $display("FAIL arith%0d_flags: got %b want %b", i, flags, e.f);
         end
         total++;
         if (lat !== 5) begin bad++; $display("FAIL arith%0d_lat: got %0d want 5", i, lat); end
      end
   endtask

   task automatic test_start_ignored;
      int   lat, bn, c;
      exp_t e;
      drive_op(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
      wait_ready(1, lat, bn);
      e = sb_q.pop_front();
      total++;
      if (y !== e.y) begin bad++; $display("FAIL ign_mul_y: got %h want %h", y, e.y); end
      total++;
      if (lat !== 5) begin bad++; $display("FAIL ign_mul_lat: got %0d want 5", lat); end
      count_ready(10, c);
      total++;
      if (c !== 0) begin bad++; $display("FAIL ign_mul_extra_ready: got %0d want 0", c); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL ign_mul_busy: got %b want 0", busy); end
      drive_op(32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
      wait_ready(4, lat, bn);
      e = sb_q.pop_front();
      total++;
      if (y !== e.y) begin bad++; $display("FAIL ign_done_y: got %h want %h", y, e.y); end
      count_ready(10, c);
      total++;
      if (c !== 0) begin bad++; $display("FAIL ign_done_extra_ready: got %0d want 0", c); end
   endtask

   task automatic test_back_to_back;
      int   lat, bn;
      exp_t e;
      drive_op(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);
      wait_ready(-1, lat, bn);
      e = sb_q.pop_front();
      total++;
      if (y !== e.y) begin bad++; $display("FAIL b2b_first_y: got %h want %h", y, e.y); end
      // start in the ready cycle, held across the following edge
      a     = 32'hC0400000;
      b     = 32'h40400000;
      start = 1'b1;
      push_exp(32'hC1100000, 4'b0000);
      @(posedge clk);
      #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
      wait_ready(-1, lat, bn);
      e = sb_q.pop_front();
      total++;
      if (lat !== 5) begin bad++; $display("FAIL b2b_lat: got %0d want 5", lat); end
      total++;
      if (y !== e.y) begin bad++; $display("FAIL b2b_second_y: got %h want %h", y, e.y); end
   endtask

   task automatic test_reset_mid;
      int c;
      drive_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(sb_q.pop_front());
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b want 0", ready); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
      total++;
      if (y !== 32'h0) begin bad++; $display("FAIL midrst_y: got %h want 00000000", y); end
      total++;
      if (flags !== 4'h0) begin bad++; $display("FAIL midrst_flags: got %b want 0000", flags); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      count_ready(12, c);
      total++;
      if (c !== 0) begin bad++; $display("FAIL midrst_late_ready: got %0d want 0", c); end
      total++;
      if (y !== 32'h0) begin bad++; $display("FAIL midrst_y_after: got %h want 00000000", y); end
   endtask

   task automatic test_half;
      logic [15:0] ha[2] = '{16'h4000, 16'h3C00};
      logic [15:0] hb[2] = '{16'h4200, 16'hBC00};
      logic [15:0] hy[2] = '{16'h4600, 16'hBC00};
      int   lat;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a_h     = ha[i];
         b_h     = hb[i];
         start_h = 1'b1;
         push_exp({16'h0, hy[i]}, 4'b0000);
         @(negedge clk);
         start_h = 1'b0;
         lat = 0;
         while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_h) break;
         end
         e = sb_q.pop_front();
         total++;
         if ({16'h0, y_h} !== e.y) begin
            bad++;
            $display("FAIL half%0d_y: got %h want %h", i, y_h, e.y[15:0]);
         end
         total++;
         if (flags_h !== e.f) begin bad++; $display("FAIL half%0d_flags: got %b want %b", i, flags_h, e.f); end
         total++;
         if (lat !== 5) begin bad++; $display("FAIL half%0d_lat: got %0d want 5", i, lat); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_half();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
